qmax_updater: RTL and testbench

Read-modify-write engine that keeps the per-state maximum Q value in the qmax table. It accepts a stream of (state, new Q) updates and reads the stored qmax for that state. It compares the two as IEEE-754 single-precision values and writes the new value back only when it is strictly larger. It sits between the Q-value update datapath and the qmax table's read/write ports, and also provides a table-clear sweep, because the table itself has no reset.

---
 rtl/qlearn_pkg.sv | 32 +++
 rtl/fp_cmp_gt.sv | 13 +
 rtl/qmax_updater.sv | 175 +++++++++++++++++
 tb/tb_qmax_updater.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// Shared Q-learning definitions: FP compare, constants, clear FSM states.
// float_gt treats +0/-0 as equal; NaN inputs are not expected.
package qlearn_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } st_e;

  function automatic logic float_gt(
    input logic [FP_W-1:0] a,
    input logic [FP_W-1:0] b
  );
    logic [FP_W-2:0] ma;
    logic [FP_W-2:0] mb;
    logic            r;
    ma = a[FP_W-2:0];
    mb = b[FP_W-2:0];
    if (a[FP_W-1] != b[FP_W-1])
      r = !a[FP_W-1] && ((ma | mb) != '0);
    else if (!a[FP_W-1])
      r = ma > mb;
    else
      r = ma < mb;
    return r;
  endfunction

endpackage

// File: rtl/fp_cmp_gt.sv
// Combinational single-precision a > b, shared with action select.
// Thin wrapper so the compare can be instantiated as a unit.
module fp_cmp_gt
  import qlearn_pkg::*;
(
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  output logic            o_gt
);

  assign o_gt = float_gt(i_a, i_b);

endmodule

// File: rtl/qmax_updater.sv
// Per-state qmax read-modify-write engine with table clear sweep.
// Three stages: read, compare with forwarding, write/result.
module qmax_updater
  import qlearn_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_clear,
  output logic                  o_clear_done,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_res_valid,
  output logic [ADDR_WIDTH-1:0] o_res_state,
  output logic [DATA_WIDTH-1:0] o_res_qmax,
  output logic                  o_res_updated
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(DEPTH - 1);

  st_e                   r_st;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_s2_v;
  logic [ADDR_WIDTH-1:0] r_s2_state;
  logic [DATA_WIDTH-1:0] r_s2_q;
  logic                  r_w_v;
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_res_valid;
  logic [ADDR_WIDTH-1:0] r_res_state;
  logic [DATA_WIDTH-1:0] r_res_qmax;
  logic                  r_res_updated;
  logic                  r_clear_done;

  logic                  w_acc;
  logic                  w_fwd_s3;
  logic                  w_fwd_w;
  logic [DATA_WIDTH-1:0] w_cur;
  logic                  w_gt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  assign w_acc     = i_valid & r_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;

  assign o_ready   = r_ready;
  assign o_rd_en   = w_acc;
  assign o_rd_addr = i_state;

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_res_valid   = r_res_valid;
  assign o_res_state   = r_res_state;
  assign o_res_qmax    = r_res_qmax;
  assign o_res_updated = r_res_updated;
  assign o_clear_done  = r_clear_done;

  // S1: capture the accepted request while the table read is issued
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_v     <= 1'b0;
      r_s2_state <= '0;
      r_s2_q     <= '0;
    end else begin
      r_s2_v     <= w_acc;
      r_s2_state <= i_state;
      r_s2_q     <= i_q;
    end
  end

  assign w_fwd_s3 = r_wr_en & (r_wr_addr == r_s2_state);
  assign w_fwd_w  = r_w_v & (r_w_addr == r_s2_state);

  // S2: newest copy of the entry; table read misses same-edge writes
  always_comb begin
    w_cur = i_rd_data;
    if (w_fwd_s3)
      w_cur = r_wr_data;
    else if (w_fwd_w)
      w_cur = r_w_data;
  end

  fp_cmp_gt u_cmp (
    .i_a  (r_s2_q),
    .i_b  (w_cur),
    .o_gt (w_gt)
  );

  // W: remembers the write committed at the previous edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w_v    <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else if (r_clear_done) begin
      r_w_v    <= 1'b0;
    end else if (r_wr_en) begin
      r_w_v    <= 1'b1;
      r_w_addr <= r_wr_addr;
      r_w_data <= r_wr_data;
    end
  end

  // S3 outputs and clear FSM; sweep owns the write port when S2 is empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st          <= ST_IDLE;
      r_ready       <= 1'b0;
      r_cnt         <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_res_valid   <= 1'b0;
      r_res_state   <= '0;
      r_res_qmax    <= '0;
      r_res_updated <= 1'b0;
      r_clear_done  <= 1'b0;
    end else begin
      r_wr_en       <= r_s2_v & w_gt;
      r_wr_addr     <= r_s2_state;
      r_wr_data     <= r_s2_q;
      r_res_valid   <= r_s2_v;
      r_res_state   <= r_s2_state;
      r_res_qmax    <= w_gt ? r_s2_q : w_cur;
      r_res_updated <= r_s2_v & w_gt;
      r_clear_done  <= 1'b0;
      unique case (r_st)
        ST_IDLE: begin
          r_ready <= ~i_clear;
          if (i_clear)
            r_st <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!r_s2_v) begin
            r_st      <= ST_CLEAR;
            r_cnt     <= '0;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= FP_ZERO;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LP_LAST) begin
            r_st    <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt        <= w_cnt_nxt;
            r_wr_en      <= 1'b1;
            r_wr_addr    <= w_cnt_nxt;
            r_wr_data    <= FP_ZERO;
            r_clear_done <= (w_cnt_nxt == LP_LAST);
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qmax_updater.sv
// Scoreboard bench for qmax_updater with a real-valued reference model.
// Table is modelled as a synchronous RAM returning old data on collisions.
module tb_qmax_updater;

  typedef struct {
    logic [5:0]  st;
    logic [31:0] qmax;
    logic        upd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_clear;
  logic [5:0]  i_state;
  logic [31:0] i_q;
  logic        o_ready, o_clear_done, o_rd_en, o_wr_en;
  logic [5:0]  o_rd_addr, o_wr_addr, o_res_state;
  logic [31:0] rd_data, o_wr_data, o_res_qmax;
  logic        o_res_valid, o_res_updated;

  logic [31:0] mem [64] = '{default: 32'h0};
  logic        pre_we = 1'b0;
  logic [5:0]  pre_a = '0;
  logic [31:0] pre_d = '0;

  logic [31:0] refq [64];
  logic [31:0] vals [16];
  exp_t        sb [$];
  exp_t        me;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, n_wr = 0;
  int          clr_mode = 0, clr_exp = 0;
  int          clr_cyc = 0, done_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qmax_updater dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_state(i_state), .i_q(i_q),
    .i_clear(i_clear), .o_clear_done(o_clear_done),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data(rd_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data),
    .o_res_valid(o_res_valid), .o_res_state(o_res_state),
    .o_res_qmax(o_res_qmax), .o_res_updated(o_res_updated)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    if (o_rd_en) rd_data <= mem[o_rd_addr];
    if (o_wr_en) mem[o_wr_addr] <= o_wr_data;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    if (b[30:23] == 8'd0)
      m = real'(b[22:0]) * (2.0 ** -149);
    else
      m = (1.0 + real'(b[22:0]) / 8388608.0)
          * (2.0 ** (real'(b[30:23]) - 127.0));
    return b[31] ? -m : m;
  endfunction

  // Monitor: pops the scoreboard on results and tracks clear sweeps
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_wr_en) n_wr++;
      if (o_res_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexp_res: state %0d", o_res_state);
        end else begin
          me = sb.pop_front();
          chk("res_state", o_res_state, me.st);
          chk("res_qmax", o_res_qmax, me.qmax);
          chk("res_upd", o_res_updated, me.upd);
          chk("wr_en", o_wr_en, me.upd);
          chk("latency", cyc, me.cyc + 2);
          if (me.upd) begin
            chk("wr_addr", o_wr_addr, me.st);
            chk("wr_data", o_wr_data, me.qmax);
          end
        end
      end else if (o_wr_en) begin
        if (clr_mode != 0) begin
          chk("clr_addr", o_wr_addr, clr_exp);
          chk("clr_data", o_wr_data, 0);
          chk("clr_done", o_clear_done, clr_exp == 63);
          if (clr_exp == 63) begin
            chk("ready_at_done", o_ready, 0);
            clr_mode = 0;
            done_cyc = cyc;
          end
          clr_exp++;
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL stray_wr: addr %0d", o_wr_addr);
        end
      end else if (o_clear_done) begin
        n_cmp++; n_bad++;
        $display("FAIL done_no_wr: got 1 want 0");
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [5:0] s,
                      input logic [31:0] q,
                      input logic clr);
    int   n;
    exp_t e;
    i_valid = 1'b1; i_state = s; i_q = q; i_clear = clr;
    #1;
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!o_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got 0 want 1");
    end else begin
      chk("rd_en", o_rd_en, 1);
      chk("rd_addr", o_rd_addr, s);
      e.st = s;
      e.cyc = cyc;
      if (f2r(q) > f2r(refq[s])) begin
        refq[s] = q; e.qmax = q; e.upd = 1'b1;
      end else begin
        e.qmax = refq[s]; e.upd = 1'b0;
      end
      sb.push_back(e);
      if (clr) begin
        clr_mode = 1; clr_exp = 0; clr_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_clear = 1'b0;
  endtask

  task automatic preload(input logic [5:0] a,
                         input logic [31:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d; refq[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("sb_empty", sb.size(), 0);
    idle(2);
  endtask

  initial begin
    vals = '{32'h00000000, 32'h80000000, 32'h3F800000,
             32'hBF800000, 32'h3FC00000, 32'hBFC00000,
             32'h40000000, 32'hC0000000, 32'h40400000,
             32'hC0400000, 32'h40800000, 32'hC0800000,
             32'h3E800000, 32'hBE800000, 32'h00000001,
             32'h80000001};
    foreach (refq[i]) refq[i] = 32'h0;
    rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
    i_state = '0; i_q = '0;
    #2;
    chk("rst_ready", o_ready, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_res_v", o_res_valid, 0);
    chk("rst_done", o_clear_done, 0);
    chk("rst_wdata", o_wr_data, 0);
    @(posedge clk); #1;
    preload(6'd9, 32'h80000000);
    preload(6'd11, 32'hC0400000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_post_rst", o_ready, 1);

    send(6'd5, 32'h3FC00000, 1'b0);
    idle(3);
    send(6'd6, 32'hC0000000, 1'b0);
    idle(3);
    send(6'd3, 32'h3F800000, 1'b0);
    send(6'd3, 32'h40400000, 1'b0);
    send(6'd3, 32'h40000000, 1'b0);
    idle(3);
    send(6'd7, 32'h40800000, 1'b0);
    idle(1);
    send(6'd7, 32'h40000000, 1'b0);
    idle(3);
    send(6'd9, 32'h00000000, 1'b0);
    send(6'd10, 32'h80000000, 1'b0);
    send(6'd11, 32'hBF800000, 1'b0);
    send(6'd5, 32'h3FC00000, 1'b0);
    drain();

    for (int k = 0; k < 150; k++) begin
      send(6'($urandom_range(0, 15)),
           vals[$urandom_range(0, 15)], 1'b0);
      idle($urandom_range(0, 2));
    end
    drain();

    send(6'd5, 32'h40A00000, 1'b1);
    chk("ready_drain", o_ready, 0);
    for (int n = 0; n < 300 && clr_mode != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("clr_finished", clr_mode, 0);
    chk("clr_lat_ok", (done_cyc - clr_cyc) <= 66, 1);
    foreach (refq[i]) refq[i] = 32'h0;
    @(posedge clk); #1;
    chk("ready_after_clr", o_ready, 1);
    send(6'd5, 32'hC0000000, 1'b0);
    send(6'd40, 32'hBF800000, 1'b0);
    send(6'd63, 32'h80000000, 1'b0);
    for (int k = 0; k < 60; k++) begin
      send(6'($urandom_range(0, 63)),
           vals[$urandom_range(0, 15)], 1'b0);
      idle($urandom_range(0, 2));
    end
    drain();

    i_clear = 1'b1; clr_mode = 1; clr_exp = 0;
    @(posedge clk); #1;
    i_clear = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (o_wr_en && o_wr_addr == 6'd20) break;
      @(posedge clk); #1;
    end
    chk("abort_at20", o_wr_addr, 20);
    rst_n = 1'b0;
    clr_mode = 0;
    #1;
    chk("abort_clr_cnt", clr_exp, 20);
    chk("abort_wr_en", o_wr_en, 0);
    chk("abort_wr_addr", o_wr_addr, 0);
    chk("abort_ready", o_ready, 0);
    chk("abort_done", o_clear_done, 0);
    for (int i = 0; i < 20; i++) refq[i] = 32'h0;
    idle(3);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_post_abort", o_ready, 1);
    begin
      int w0;
      w0 = n_wr;
      idle(6);
      chk("no_wr_after", n_wr - w0, 0);
    end
    send(6'd30, 32'h40000000, 1'b0);
    send(6'd2, 32'h3F800000, 1'b0);
    drain();

    foreach (mem[i]) chk($sformatf("mem%0d", i), mem[i], refq[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
